nibble_serial_addsub_ctrl: RTL and testbench

Sequencer that performs WIDTH-bit add/subtract by time-multiplexing a single 4-bit parallel adder/subtractor slice. The slice is instantiated internally and driven with one nibble per cycle, LSB first, with the carry chained through a register. Valid/ready handshakes on the command and result sides let a wider datapath share the small slice instead of instantiating WIDTH/4 slices.

---
 rtl/nibble_serial_addsub_ctrl.sv | 128 ++++++++++++
 tb/tb_nibble_serial_addsub_ctrl.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/nibble_serial_addsub_ctrl.sv
// Serial WIDTH-bit add/subtract built from one 4-bit add/sub slice.
// Nibbles are processed LSB first, with the carry held in a register between steps.

module nibble_addsub_slice (
  input  logic [3:0] a_i,
  input  logic [3:0] b_i,
  input  logic       k_i,
  input  logic       cin_i,
  output logic [3:0] s_o,
  output logic       cout_o
);
  logic [4:0] sum_c;

  // Subtract is A + ~B + 1; the +1 comes in through cin on the first nibble.
  assign sum_c  = 5'(a_i) + 5'(b_i ^ {4{k_i}}) + 5'(cin_i);
  assign s_o    = sum_c[3:0];
  assign cout_o = sum_c[4];
endmodule

module nibble_serial_addsub_ctrl #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             k,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             ovf
);
  localparam int unsigned NIB = WIDTH / 4;
  localparam int unsigned CW  = (NIB > 1) ? $clog2(NIB) : 1;

  if (((WIDTH % 4) != 0) || (WIDTH < 4)) begin : g_bad_width
    $error("nibble_serial_addsub_ctrl: WIDTH must be a multiple of 4 and at least 4");
  end

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q;
  logic [WIDTH-1:0] a_q, b_q, s_q;
  logic             k_q, carry_q, in_ready_q, out_valid_q, cout_q, ovf_q;
  logic [CW-1:0]    idx_q;

  logic [3:0]       a_nib_c, b_nib_c, sl_s_c;
  logic             sl_cout_c, last_c, ovf_c;

  assign a_nib_c = a_q[{idx_q, 2'b00} +: 4];
  assign b_nib_c = b_q[{idx_q, 2'b00} +: 4];
  assign last_c  = (idx_q == CW'(NIB - 1));

  nibble_addsub_slice u_slice (
    .a_i    (a_nib_c),
    .b_i    (b_nib_c),
    .k_i    (k_q),
    .cin_i  (carry_q),
    .s_o    (sl_s_c),
    .cout_o (sl_cout_c)
  );

  // Operand sign bits are registered; only the result sign comes from the final slice step.
  assign ovf_c = (a_q[WIDTH-1] == (b_q[WIDTH-1] ^ k_q)) && (sl_s_c[3] != a_q[WIDTH-1]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      s_q         <= '0;
      k_q         <= 1'b0;
      carry_q     <= 1'b0;
      idx_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      cout_q      <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid && in_ready_q) begin
            a_q        <= a;
            b_q        <= b;
            k_q        <= k;
            carry_q    <= k;
            idx_q      <= '0;
            in_ready_q <= 1'b0;
            state_q    <= RUN;
          end
        end
        RUN: begin
          s_q[{idx_q, 2'b00} +: 4] <= sl_s_c;
          carry_q                  <= sl_cout_c;
          idx_q                    <= idx_q + CW'(1);
          if (last_c) begin
            idx_q       <= '0;
            out_valid_q <= 1'b1;
            cout_q      <= sl_cout_c;
            ovf_q       <= ovf_c;
            state_q     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: begin
          state_q     <= IDLE;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign s         = s_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;
endmodule

// File: tb/tb_nibble_serial_addsub_ctrl.sv
// Directed and randomized checks of the serial add/sub sequencer at WIDTH=16 and WIDTH=4.

module tb_nibble_serial_addsub_ctrl;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        in_valid, in_ready, k, out_valid, out_ready, cout, ovf;
  logic [15:0] a, b, s;
  logic        in_valid4, in_ready4, k4, out_valid4, out_ready4, cout4, ovf4;
  logic [3:0]  a4, b4, s4;

  int n_cmp = 0;
  int n_err = 0;

  nibble_serial_addsub_ctrl #(.WIDTH(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .k(k), .out_valid(out_valid), .out_ready(out_ready),
    .s(s), .cout(cout), .ovf(ovf)
  );

  nibble_serial_addsub_ctrl #(.WIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid4), .in_ready(in_ready4),
    .a(a4), .b(b4), .k(k4), .out_valid(out_valid4), .out_ready(out_ready4),
    .s(s4), .cout(cout4), .ovf(ovf4)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Whole-word reference: returns {ovf, cout, s}.
  function automatic logic [17:0] ref16(input logic [15:0] av, input logic [15:0] bv, input logic kv);
    logic [15:0] bp;
    logic [16:0] sum;
    bp  = bv ^ {16{kv}};
    sum = {1'b0, av} + {1'b0, bp} + 17'(kv);
    return {((av[15] == bp[15]) && (sum[15] != av[15])), sum};
  endfunction

  function automatic logic [5:0] ref4(input logic [3:0] av, input logic [3:0] bv, input logic kv);
    logic [3:0] bp;
    logic [4:0] sum;
    bp  = bv ^ {4{kv}};
    sum = {1'b0, av} + {1'b0, bp} + 5'(kv);
    return {((av[3] == bp[3]) && (sum[3] != av[3])), sum};
  endfunction

  task automatic op16(input logic [15:0] av, input logic [15:0] bv, input logic kv,
                      input logic [17:0] exp, input int stall);
    int n;
    n = 0;
    while (!in_ready && n < 20) begin @(posedge clk); #1; n++; end
    chk("in_ready16_idle", 32'(in_ready), 32'd1);
    in_valid = 1'b1; a = av; b = bv; k = kv;
    @(posedge clk); #1;
    in_valid = 1'b0; a = 16'($urandom); b = 16'($urandom); k = 1'($urandom);
    n = 0;
    while (!out_valid && n < 20) begin @(posedge clk); #1; n++; end
    chk("latency16", 32'(n), 32'd4);
    for (int i = 0; i < stall; i++) begin
      chk("stall16_in_ready", 32'(in_ready), 32'd0);
      chk("stall16_s", 32'(s), 32'(exp[15:0]));
      @(posedge clk); #1;
    end
    chk("valid16", 32'(out_valid), 32'd1);
    chk("s16", 32'(s), 32'(exp[15:0]));
    chk("cout16", 32'(cout), 32'(exp[16]));
    chk("ovf16", 32'(ovf), 32'(exp[17]));
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("release16_valid", 32'(out_valid), 32'd0);
    chk("release16_ready", 32'(in_ready), 32'd1);
  endtask

  task automatic op4(input logic [3:0] av, input logic [3:0] bv, input logic kv,
                     input logic [5:0] exp, input int stall);
    int n;
    n = 0;
    while (!in_ready4 && n < 20) begin @(posedge clk); #1; n++; end
    chk("in_ready4_idle", 32'(in_ready4), 32'd1);
    in_valid4 = 1'b1; a4 = av; b4 = bv; k4 = kv;
    @(posedge clk); #1;
    in_valid4 = 1'b0; a4 = 4'($urandom); b4 = 4'($urandom); k4 = 1'($urandom);
    n = 0;
    while (!out_valid4 && n < 20) begin @(posedge clk); #1; n++; end
    chk("latency4", 32'(n), 32'd1);
    for (int i = 0; i < stall; i++) begin
      chk("stall4_s", 32'(s4), 32'(exp[3:0]));
      @(posedge clk); #1;
    end
    chk("s4", 32'(s4), 32'(exp[3:0]));
    chk("cout4", 32'(cout4), 32'(exp[4]));
    chk("ovf4", 32'(ovf4), 32'(exp[5]));
    out_ready4 = 1'b1;
    @(posedge clk); #1;
    out_ready4 = 1'b0;
    chk("release4_valid", 32'(out_valid4), 32'd0);
  endtask

  initial begin
    int n;
    int acc[$];
    logic [15:0] ra, rb;
    logic [3:0]  ra4, rb4;
    logic        rk;

    rst_n = 1'b0;
    in_valid = 1'b0; a = '0; b = '0; k = 1'b0; out_ready = 1'b0;
    in_valid4 = 1'b0; a4 = '0; b4 = '0; k4 = 1'b0; out_ready4 = 1'b0;
    #12;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_s", 32'(s), 32'd0);
    chk("rst_cout_ovf", 32'({cout, ovf}), 32'd0);
    chk("rst4_in_ready", 32'(in_ready4), 32'd1);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    // Hand-computed vectors: {ovf, cout, s}
    op16(16'h1234, 16'h0FFF, 1'b0, 18'h02233, 0);
    op16(16'h0005, 16'h0007, 1'b1, 18'h0FFFE, 0);
    op16(16'h8000, 16'h0001, 1'b1, 18'h37FFF, 1);
    op16(16'h7FFF, 16'h0001, 1'b0, 18'h28000, 0);
    op16(16'hFFFF, 16'h0001, 1'b0, 18'h10000, 2);

    // Backpressure with a stray command held on in_valid through RUN and DONE.
    in_valid = 1'b1; a = 16'h0002; b = 16'h0003; k = 1'b0;
    @(posedge clk); #1;
    a = 16'h1111; b = 16'h1111;
    n = 0;
    while (!out_valid && n < 20) begin
      chk("run_in_ready", 32'(in_ready), 32'd0);
      @(posedge clk); #1; n++;
    end
    chk("bp_latency", 32'(n), 32'd4);
    for (int i = 0; i < 10; i++) begin
      chk("bp_valid", 32'(out_valid), 32'd1);
      chk("bp_s", 32'(s), 32'h0005);
      chk("bp_cout_ovf", 32'({cout, ovf}), 32'd0);
      chk("bp_in_ready", 32'(in_ready), 32'd0);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("no_queued_cmd", 32'(out_valid), 32'd0);
    chk("idle_after_ignore", 32'(in_ready), 32'd1);
    op16(16'h0004, 16'h0004, 1'b0, 18'h00008, 0);

    // Back-to-back: NIB RUN edges, one DONE release edge, then the IDLE accept edge.
    out_ready = 1'b1; in_valid = 1'b1; a = 16'h0101; b = 16'h0202; k = 1'b0;
    for (int c = 0; c < 20; c++) begin
      if (in_ready) acc.push_back(c);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk("b2b_count", 32'(acc.size()), 32'd4);
    chk("b2b_gap0", (acc.size() >= 2) ? 32'(acc[1] - acc[0]) : 32'hFFFF_FFFF, 32'd6);
    chk("b2b_gap1", (acc.size() >= 3) ? 32'(acc[2] - acc[1]) : 32'hFFFF_FFFF, 32'd6);
    chk("b2b_s", 32'(s), 32'h0303);

    // Reset during the second RUN cycle of 0xAAAA + 0x5555.
    in_valid = 1'b1; a = 16'hAAAA; b = 16'h5555; k = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_s", 32'(s), 32'd0);
    chk("midrst_valid", 32'(out_valid), 32'd0);
    chk("midrst_cout_ovf", 32'({cout, ovf}), 32'd0);
    chk("midrst_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk) rst_n = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    chk("postrst_no_result", 32'(out_valid), 32'd0);
    chk("postrst_in_ready", 32'(in_ready), 32'd1);
    op16(16'h0001, 16'h0001, 1'b0, 18'h00002, 0);

    // WIDTH=4 directed: {ovf, cout, s}
    op4(4'h7, 4'h1, 1'b0, 6'b10_1000, 0);
    op4(4'h3, 4'h5, 1'b1, 6'b00_1110, 1);
    op4(4'hF, 4'h1, 1'b0, 6'b01_0000, 0);

    for (int i = 0; i < 300; i++) begin
      ra = 16'($urandom); rb = 16'($urandom); rk = 1'($urandom);
      op16(ra, rb, rk, ref16(ra, rb, rk), int'($urandom_range(0, 3)));
    end
    for (int i = 0; i < 200; i++) begin
      ra4 = 4'($urandom); rb4 = 4'($urandom); rk = 1'($urandom);
      op4(ra4, rb4, rk, ref4(ra4, rb4, rk), int'($urandom_range(0, 3)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
